// File: rtl/phy_tx_sched_if.sv
// phy_tx_sched bus: requester FIFO heads and pops in,
// scheduled phy symbol stream out.
interface phy_tx_sched_if #(
    parameter int N_REQ  = 4,
    parameter int DATA_W = 8
);
    logic [N_REQ-1:0]         fifo_empty;
    logic [N_REQ*DATA_W-1:0]  fifo_data;
    logic [N_REQ-1:0]         fifo_pop;
    logic                     phy_ready;
    logic [DATA_W-1:0]        data_out;
    logic                     valid_out;
    logic                     active_out;
    logic [$clog2(N_REQ)-1:0] grant_id;

    modport master (
        output fifo_empty, fifo_data, phy_ready,
        input  fifo_pop, data_out, valid_out,
        input  active_out, grant_id
    );

    modport slave (
        input  fifo_empty, fifo_data, phy_ready,
        output fifo_pop, data_out, valid_out,
        output active_out, grant_id
    );
endinterface

// File: rtl/phy_tx_sched.sv
// PCIe phy transmit scheduler: COM training burst, then
// round-robin FIFO data with periodic COM and IDLE fill.
module phy_tx_sched #(
    parameter int          N_REQ       = 4,
    parameter int          DATA_W      = 8,
    parameter logic [7:0]  COM_SYM     = 8'hBC,
    parameter logic [7:0]  IDLE_SYM    = 8'h7C,
    parameter int          INIT_COM    = 4,
    parameter int          SKIP_PERIOD = 16
) (
    input logic           clk,
    input logic           reset,
    phy_tx_sched_if.slave bus
);
    localparam int GW = $clog2(N_REQ);
    localparam int IW = (INIT_COM > 1) ? $clog2(INIT_COM) : 1;
    localparam int SW = (SKIP_PERIOD > 1) ? $clog2(SKIP_PERIOD) : 1;

    typedef enum logic {
        S_INIT,
        S_ACTIVE
    } state_t;

    state_t            r_state;
    logic [IW-1:0]     r_init_cnt;
    logic [SW-1:0]     r_skip_cnt;
    logic [DATA_W-1:0] r_data;
    logic              r_valid;
    logic              r_active;
    logic [GW-1:0]     r_grant;

    logic              w_found;
    logic [GW-1:0]     w_gnt;
    logic [GW-1:0]     w_idx;
    logic              w_com_slot;
    logic              w_pop_en;
    logic [N_REQ-1:0]  w_pop;
    logic [DATA_W-1:0] w_head;

    // Round-robin search: nearest non-empty FIFO after the last grant.
    always_comb begin
        w_found = 1'b0;
        w_gnt   = r_grant;
        w_idx   = '0;
        for (int k = N_REQ; k >= 1; k--) begin
            w_idx = GW'((int'(r_grant) + k) % N_REQ);
            if (!bus.fifo_empty[w_idx]) begin
                w_found = 1'b1;
                w_gnt   = w_idx;
            end
        end
    end

    assign w_com_slot = (r_skip_cnt == SW'(SKIP_PERIOD - 1));
    assign w_pop_en   = !reset && bus.phy_ready &&
                        (r_state == S_ACTIVE) &&
                        !w_com_slot && w_found;
    assign w_head     = bus.fifo_data[int'(w_gnt)*DATA_W +: DATA_W];

    // One-hot pop of the granted FIFO in data slots only.
    always_comb begin
        w_pop = '0;
        if (w_pop_en) begin
            w_pop[w_gnt] = 1'b1;
        end
    end

    // Link sequencer: training burst, then COM/data/IDLE slots.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= S_INIT;
            r_init_cnt <= '0;
            r_skip_cnt <= '0;
            r_data     <= '0;
            r_valid    <= 1'b0;
            r_active   <= 1'b0;
            r_grant    <= GW'(N_REQ - 1);
        end else if (bus.phy_ready) begin
            unique case (r_state)
                S_INIT: begin
                    r_data  <= COM_SYM;
                    r_valid <= 1'b0;
                    if (r_init_cnt == IW'(INIT_COM - 1)) begin
                        r_state    <= S_ACTIVE;
                        r_active   <= 1'b1;
                        r_skip_cnt <= '0;
                        r_init_cnt <= '0;
                    end else begin
                        r_init_cnt <= r_init_cnt + 1'b1;
                    end
                end
                S_ACTIVE: begin
                    if (w_com_slot) begin
                        r_data     <= COM_SYM;
                        r_valid    <= 1'b0;
                        r_skip_cnt <= '0;
                    end else if (w_found) begin
                        r_data     <= w_head;
                        r_valid    <= 1'b1;
                        r_grant    <= w_gnt;
                        r_skip_cnt <= r_skip_cnt + 1'b1;
                    end else begin
                        r_data     <= IDLE_SYM;
                        r_valid    <= 1'b0;
                        r_skip_cnt <= r_skip_cnt + 1'b1;
                    end
                end
                default: r_state <= S_INIT;
            endcase
        end
    end

    assign bus.fifo_pop   = w_pop;
    assign bus.data_out   = r_data;
    assign bus.valid_out  = r_valid;
    assign bus.active_out = r_active;
    assign bus.grant_id   = r_grant;
endmodule

// File: doc/phy_tx_sched.md
Name: phy_tx_sched

Overview:
- Transmit-side scheduler for the PCIe phy.
- Shares the phy's single 8-bit parallel transmit input between 4 requester FIFOs using round-robin arbitration.
- Sequences the link: a COM training burst after reset, then data, with periodic COM insertion and IDLE fill when no requester has data.
- Sits between the per-lane/virtual-channel FIFOs and the phy parallel-to-serial input, in the phy's clock domain.

Parameters:
- N_REQ, 4, number of requester FIFOs (arbiter written for 4; width of fifo_empty/fifo_pop).
- DATA_W, 8, symbol width.
- COM_SYM, 8'hBC, comma symbol.
- IDLE_SYM, 8'h7C, idle fill symbol.
- INIT_COM, 4, COM symbols sent after reset before data is allowed.
- SKIP_PERIOD, 16, a COM is inserted after every SKIP_PERIOD-1 consecutive symbol slots in ACTIVE.

Ports:
- clk  in  1  phy parallel clock; all logic on rising edge.
- reset  in  1  synchronous, active-high reset.
- fifo_empty  in  N_REQ  bit i high = requester FIFO i empty.
- fifo_data  in  N_REQ*DATA_W  show-ahead head word of FIFO i at bits [i*8+7:i*8].
- fifo_pop  out  N_REQ  one-hot combinational pop; FIFO i advances at the edge where bit i is high.
- phy_ready  in  1  phy accepts a symbol this cycle.
- data_out  out  DATA_W  registered symbol to phy.
- valid_out  out  1  registered; high when data_out carries FIFO data.
- active_out  out  1  registered; high in ACTIVE state.
- grant_id  out  2  registered index of the last granted requester.

Behaviour:
- Reset (clk edge with reset=1):
  - state=INIT, data_out=8'h00, valid_out=0, active_out=0, grant_id=3 (so first grant goes to 0).
  - init counter=0, skip counter=0; fifo_pop forced 0 while reset=1.
- Reset asserted mid-operation:
  - Same values at the next edge.
  - No pop is issued in a cycle with reset=1.
  - The symbol in flight is dropped; the FIFO keeps it if it was not popped.
- phy_ready=0:
  - No pop; all registers hold (data_out, valid_out, counters, grant_id, state).
- State INIT, phy_ready=1:
  - data_out<=COM_SYM, valid_out<=0, init counter++.
  - When the counter reaches INIT_COM-1 on this edge: next state ACTIVE, active_out<=1, skip counter<=0.
  - Exactly INIT_COM COM symbols are emitted.
- State ACTIVE, phy_ready=1, priority order:
  1. Skip counter == SKIP_PERIOD-1: data_out<=COM_SYM, valid_out<=0, skip counter<=0, no pop, grant_id unchanged.
  2. Else if any fifo_empty bit is 0:
     - g = first non-empty index searching grant_id+1, grant_id+2, … mod 4.
     - fifo_pop[g]=1 combinationally this cycle.
     - data_out<=fifo_data[g], valid_out<=1, grant_id<=g, skip counter++.
  3. Else: data_out<=IDLE_SYM, valid_out<=0, skip counter++, no pop.
- Latency: FIFO head word appears on data_out 1 cycle after its pop cycle.
- fifo_pop is at most one-hot and never asserted for an empty FIFO, in INIT, during reset, or when phy_ready=0.
- Fairness: with all 4 FIFOs non-empty and no COM slot, grants cycle 0,1,2,3,0,…
- A COM slot does not advance the round-robin pointer.
- Skip counter wraps 0..SKIP_PERIOD-1 and counts only phy_ready=1 slots in ACTIVE.
- Counter widths are sized with $clog2; no overflow beyond the parameter bound.
- No return from ACTIVE to INIT except through reset.

Test Plan:
- Reset 2 cycles, all FIFOs empty, phy_ready=1 → data_out 00, then BC for 4 cycles (valid_out=0), then active_out=1 and data_out=7C every cycle except BC on the 16th ACTIVE slot.
- After INIT, FIFO0 holds {11,22,33}, others empty → pops on 3 consecutive cycles; data_out 11,22,33 with valid_out=1 one cycle after each pop; then 7C.
- All four FIFOs hold words (A0,B0,C0,D0,A1…) → output order A0,B0,C0,D0,A1,B1…; grant_id 0,1,2,3,0; BC inserted at slot 15 and the grant resumes where it left off.
- Toggle phy_ready 1,0,0,1 with FIFO2 non-empty → no pop and outputs frozen during ready=0; pop resumes on the next ready=1; the skip counter does not advance while stalled.
- Only FIFO1 and FIFO3 non-empty, grant_id=1 → next grant 3, then 1; fifo_pop never 4'b0101 or any multi-hot value (assertion over the whole run).
- Assert reset for 1 cycle during ACTIVE with FIFO0 non-empty → fifo_pop=0 that cycle; next cycle state=INIT, 4 BC symbols reissued; FIFO0 data then delivered intact.
